// File: rtl/systolic_array_ctrl.sv
// Sequencer for a SIZE x SIZE systolic array: fetches K operand slices, skews them
// lane-by-lane onto the array edges, then waits for the wavefront to drain before flagging done.
module systolic_array_ctrl #(
   parameter int unsigned SIZE       = 16,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned K_WIDTH    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [K_WIDTH-1:0]           k_len,
   output logic                         busy,
   output logic                         done,
   output logic                         op_rd_en,
   output logic [K_WIDTH-1:0]           op_rd_addr,
   input  logic [SIZE*DATA_WIDTH-1:0]   a_rd_data,
   input  logic [SIZE*DATA_WIDTH-1:0]   b_rd_data,
   output logic [SIZE*DATA_WIDTH-1:0]   west_inputs,
   output logic [SIZE*DATA_WIDTH-1:0]   north_inputs,
   output logic                         accum_reset,
   output logic                         result_valid
);

   localparam int unsigned DrainW = $clog2(2 * SIZE);
   localparam logic [DrainW-1:0] DrainLast = DrainW'(2 * SIZE - 2);

   typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [K_WIDTH-1:0]  k_len_q, k_len_d;
   logic [K_WIDTH-1:0]  k_cnt_q, k_cnt_d;
   logic [DrainW-1:0]   drain_q, drain_d;
   logic                accum_q, accum_d;
   logic                rd_vld_q, rd_vld_d;
   logic [SIZE-2:0]     vld_sh_q, vld_sh_d;
   logic [SIZE-1:0]     lane_vld;

   always_comb begin
      state_d = state_q;
      k_len_d = k_len_q;
      k_cnt_d = k_cnt_q;
      drain_d = drain_q;
      accum_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               k_len_d = k_len;
               k_cnt_d = '0;
               accum_d = 1'b1;
               state_d = (k_len == '0) ? StDone : StFeed;
            end
         end
         StFeed: begin
            if (k_cnt_q == k_len_q - K_WIDTH'(1)) begin
               k_cnt_d = '0;
               drain_d = '0;
               state_d = StDrain;
            end else begin
               k_cnt_d = k_cnt_q + K_WIDTH'(1);
            end
         end
         StDrain: begin
            // 2*SIZE-1 drain cycles: last slice crosses SIZE-1 skew stages and SIZE-1 PE hops
            if (drain_q == DrainLast) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q + DrainW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         k_len_q <= '0;
         k_cnt_q <= '0;
         drain_q <= '0;
         accum_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_len_q <= k_len_d;
         k_cnt_q <= k_cnt_d;
         drain_q <= drain_d;
         accum_q <= accum_d;
      end
   end

   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign result_valid = done;
   assign op_rd_en     = (state_q == StFeed);
   assign op_rd_addr   = k_cnt_q;
   assign accum_reset  = accum_q;

   // Buffer data is valid the cycle after a read; lane i sees that valid delayed i cycles.
   assign lane_vld = {vld_sh_q, rd_vld_q};

   always_comb begin
      rd_vld_d = op_rd_en;
      vld_sh_d = lane_vld[SIZE-2:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
         vld_sh_q <= '0;
      end else begin
         rd_vld_q <= rd_vld_d;
         vld_sh_q <= vld_sh_d;
      end
   end

   for (genvar i = 0; i < SIZE; i++) begin : g_lane
      if (i == 0) begin : g_direct
         assign west_inputs[0 +: DATA_WIDTH]  = lane_vld[0] ? a_rd_data[0 +: DATA_WIDTH] : '0;
         assign north_inputs[0 +: DATA_WIDTH] = lane_vld[0] ? b_rd_data[0 +: DATA_WIDTH] : '0;
      end else begin : g_skew
         logic [i*DATA_WIDTH-1:0] a_pipe_q, a_pipe_d;
         logic [i*DATA_WIDTH-1:0] b_pipe_q, b_pipe_d;

         always_comb begin
            a_pipe_d = a_pipe_q << DATA_WIDTH;
            b_pipe_d = b_pipe_q << DATA_WIDTH;
            a_pipe_d[DATA_WIDTH-1:0] = a_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            b_pipe_d[DATA_WIDTH-1:0] = b_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_pipe_q <= '0;
               b_pipe_q <= '0;
            end else begin
               a_pipe_q <= a_pipe_d;
               b_pipe_q <= b_pipe_d;
            end
         end

         assign west_inputs[i*DATA_WIDTH +: DATA_WIDTH] =
            lane_vld[i] ? a_pipe_q[(i-1)*DATA_WIDTH +: DATA_WIDTH] : '0;
         assign north_inputs[i*DATA_WIDTH +: DATA_WIDTH] =
            lane_vld[i] ? b_pipe_q[(i-1)*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
   end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Randomized bench for systolic_array_ctrl: cycle-level expectations derived from start cycle
// and K, plus a behavioural PE grid fed by the DUT edges and checked against A*B.
module tb_systolic_array_ctrl;

   localparam int SIZE = 16;
   localparam int DW   = 8;
   localparam int KW   = 16;
   localparam int LW   = SIZE * DW;

   logic           clk, rst, start;
   logic [KW-1:0]  k_len;
   logic           busy, done, op_rd_en, accum_reset, result_valid;
   logic [KW-1:0]  op_rd_addr;
   logic [LW-1:0]  a_rd_data, b_rd_data, west_inputs, north_inputs;

   systolic_array_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .k_len        (k_len),
      .busy         (busy),
      .done         (done),
      .op_rd_en     (op_rd_en),
      .op_rd_addr   (op_rd_addr),
      .a_rd_data    (a_rd_data),
      .b_rd_data    (b_rd_data),
      .west_inputs  (west_inputs),
      .north_inputs (north_inputs),
      .accum_reset  (accum_reset),
      .result_valid (result_valid)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [LW-1:0] mem_a [64];
   logic [LW-1:0] mem_b [64];

   // model state
   bit has_run = 0;
   int rs = 0, rk = 0;
   int acc [SIZE][SIZE];
   logic signed [DW-1:0] a_reg [SIZE][SIZE];
   logic signed [DW-1:0] b_reg [SIZE][SIZE];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s @cyc %0d: got %0h required %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_busy"}, LW'(busy), '0);
      check_eq({tag, "_done"}, LW'(done), '0);
      check_eq({tag, "_rden"}, LW'(op_rd_en), '0);
      check_eq({tag, "_addr"}, LW'(op_rd_addr), '0);
      check_eq({tag, "_accr"}, LW'(accum_reset), '0);
      check_eq({tag, "_rv"}, LW'(result_valid), '0);
      check_eq({tag, "_west"}, west_inputs, '0);
      check_eq({tag, "_north"}, north_inputs, '0);
   endtask

   task automatic clear_pe();
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++) begin
            acc[r][c] = 0;
            a_reg[r][c] = '0;
            b_reg[r][c] = '0;
         end
   endtask

   // Operand buffers: one-cycle read latency, garbage when not read.
   initial begin
      logic en;
      logic [KW-1:0] ad;
      a_rd_data = '0;
      b_rd_data = '0;
      forever begin
         @(negedge clk);
         en = op_rd_en;
         ad = op_rd_addr;
         @(posedge clk);
         #1;
         if (en) begin
            a_rd_data = mem_a[ad[5:0]];
            b_rd_data = mem_b[ad[5:0]];
         end else begin
            a_rd_data = {$urandom, $urandom, $urandom, $urandom};
            b_rd_data = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // Per-cycle reference: everything follows from the run's start cycle rs and depth rk.
   initial begin
      int t, rdone, kk, errs, ec;
      bit e_busy, e_done, e_en, e_ar;
      logic [LW-1:0] e_w, e_n;
      logic signed [DW-1:0] ai, bi;
      clear_pe();
      forever begin
         @(negedge clk);
         if (rst) begin
            has_run = 0;
            clear_pe();
         end else begin
            t = cyc;
            rdone  = (rk == 0) ? rs + 1 : rs + rk + 2 * SIZE;
            e_busy = has_run && t >= rs + 1 && t <= rdone;
            e_done = has_run && t == rdone;
            e_en   = has_run && rk > 0 && t >= rs + 1 && t <= rs + rk;
            e_ar   = has_run && t == rs + 1;
            e_w = '0;
            e_n = '0;
            for (int i = 0; i < SIZE; i++) begin
               kk = t - rs - 2 - i;
               if (has_run && kk >= 0 && kk < rk) begin
                  e_w[i*DW +: DW] = mem_a[kk][i*DW +: DW];
                  e_n[i*DW +: DW] = mem_b[kk][i*DW +: DW];
               end
            end
            check_eq("busy", LW'(busy), LW'(e_busy));
            check_eq("done", LW'(done), LW'(e_done));
            check_eq("result_valid", LW'(result_valid), LW'(e_done));
            check_eq("op_rd_en", LW'(op_rd_en), LW'(e_en));
            check_eq("accum_reset", LW'(accum_reset), LW'(e_ar));
            check_eq("west", west_inputs, e_w);
            check_eq("north", north_inputs, e_n);
            if (e_en) check_eq("op_rd_addr", LW'(op_rd_addr), LW'(t - rs - 1));

            if (e_done && rk > 0) begin
               errs = 0;
               for (int r = 0; r < SIZE; r++)
                  for (int c = 0; c < SIZE; c++) begin
                     ec = 0;
                     for (int k = 0; k < rk; k++)
                        ec += int'($signed(mem_a[k][r*DW +: DW])) *
                              int'($signed(mem_b[k][c*DW +: DW]));
                     if (acc[r][c] != ec) errs++;
                  end
               check_eq("gemm_result_errs", LW'(errs), '0);
            end

            // behavioural PE grid driven by the DUT's edge outputs
            for (int r = SIZE - 1; r >= 0; r--)
               for (int c = SIZE - 1; c >= 0; c--) begin
                  ai = (c == 0) ? $signed(west_inputs[r*DW +: DW]) : a_reg[r][c-1];
                  bi = (r == 0) ? $signed(north_inputs[c*DW +: DW]) : b_reg[r-1][c];
                  acc[r][c] = accum_reset ? 0 : acc[r][c] + int'(ai) * int'(bi);
                  a_reg[r][c] = ai;
                  b_reg[r][c] = bi;
               end

            if (!e_busy && start) begin
               has_run = 1;
               rs = t;
               rk = int'(k_len);
            end
         end
      end
   end

   task automatic fill_random();
      for (int k = 0; k < 64; k++) begin
         mem_a[k] = {$urandom, $urandom, $urandom, $urandom};
         mem_b[k] = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic run_gemm(input int k);
      @(posedge clk); #1;
      start = 1'b1;
      k_len = KW'(k);
      @(posedge clk); #1;
      start = 1'b0;
      k_len = KW'($urandom);
      repeat (k + 2 * SIZE + 3) @(posedge clk);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      k_len = '0;
      fill_random();
      repeat (3) @(posedge clk);
      #1;
      check_quiet("in_reset");
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_quiet("idle");

      // identity slices
      for (int k = 0; k < 64; k++) begin
         mem_a[k] = '0;
         mem_b[k] = '0;
         if (k < SIZE) begin
            mem_a[k][k*DW +: DW] = 8'd1;
            mem_b[k][k*DW +: DW] = 8'd1;
         end
      end
      run_gemm(4);

      // skew: lane r carries r+1
      fill_random();
      for (int r = 0; r < SIZE; r++) mem_a[0][r*DW +: DW] = DW'(r + 1);
      run_gemm(1);

      run_gemm(0);

      // start held high: back-to-back runs, start during busy ignored
      fill_random();
      @(posedge clk); #1;
      start = 1'b1;
      k_len = KW'(2);
      repeat (2 * (2 + 2 * SIZE) + 10) @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2 * SIZE + 10) @(posedge clk);

      for (int i = 0; i < 5; i++) begin
         fill_random();
         run_gemm(int'($urandom_range(1, 20)));
      end

      // reset mid-run at S+10 of a K=8 run
      fill_random();
      @(posedge clk); #1;
      start = 1'b1;
      k_len = KW'(8);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_quiet("async_rst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);

      fill_random();
      run_gemm(5);
      repeat (5) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
